// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-back arbiter in front of the 16-entry register file's single write
//   port. Source 0 is the ALU result path and source 1 is the load/memory
//   result path. Each source owns a one-entry holding buffer. Full buffers are
//   granted round-robin, but two buffers that target the same register are
//   granted oldest-first. The granted entry is registered onto the write
//   port (rf_le/rf_rw/rf_pw), which drives the register file directly.
//
//   Handshake: source n transfers a write on a rising edge where
//   sn_valid & sn_ready. sn_ready depends only on internal state and reset,
//   and never on sn_valid. sn_ready is high when buffer n is empty or is being
//   granted this cycle.
//
// Parameters
//   DATA_W        write data width (matches register file PW)
//   ADDR_W        register index width (matches register file RW)
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   s0_valid/ready/rd/data        ALU write-back source
//   s1_valid/ready/rd/data        load/memory write-back source
//   rf_le, rf_rw, rf_pw           registered register file write port
//   pending_mask                  bit i set while a write to Ri is in flight
//   wr_err                        one-cycle pulse: an accepted write targeted R15
//   fwd_ra, fwd_hit, fwd_data     forwarding lookup of in-flight writes
// Build option
//   RFWB_FWD_EN   builds the forwarding comparators. Without it, fwd_hit and
//                 fwd_data are tied to zero.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_rd,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_rd,
  input  logic [DATA_W-1:0] s1_data,
  output logic              rf_le,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_pw,
  output logic [15:0]       pending_mask,
  output logic              wr_err,
  input  logic [ADDR_W-1:0] fwd_ra,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  localparam logic [ADDR_W-1:0] PC_IDX = '1;

  logic              b0_full_q, b0_full_d, b1_full_q, b1_full_d;
  logic [ADDR_W-1:0] b0_rd_q, b0_rd_d, b1_rd_q, b1_rd_d;
  logic [DATA_W-1:0] b0_data_q, b0_data_d, b1_data_q, b1_data_d;
  // older0_q: buffer 0 holds the older entry (or both loaded on the same edge)
  logic              older0_q, older0_d;
  // last_q: most recently granted source (1 at reset so source 0 goes first)
  logic              last_q, last_d;
  logic              rf_le_q, rf_le_d;
  logic [ADDR_W-1:0] rf_rw_q, rf_rw_d;
  logic [DATA_W-1:0] rf_pw_q, rf_pw_d;
  logic              wr_err_q, wr_err_d;

  logic gnt0, gnt1;
  logic acc0, acc1, pc0, pc1, load0, load1, keep0, keep1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (b0_full_q && b1_full_q) begin
      // Same destination: oldest first, so the newest value lands last.
      if (b0_rd_q == b1_rd_q) gnt0 = older0_q;
      else                    gnt0 = last_q;
      gnt1 = ~gnt0;
    end else begin
      gnt0 = b0_full_q;
      gnt1 = b1_full_q;
    end
  end

  assign s0_ready = ~reset & (~b0_full_q | gnt0);
  assign s1_ready = ~reset & (~b1_full_q | gnt1);

  assign acc0  = s0_valid & s0_ready;
  assign acc1  = s1_valid & s1_ready;
  assign pc0   = (s0_rd == PC_IDX);
  assign pc1   = (s1_rd == PC_IDX);
  // Writes to the PC are dropped here and only flagged.
  assign load0 = acc0 & ~pc0;
  assign load1 = acc1 & ~pc1;
  assign keep0 = b0_full_q & ~gnt0;
  assign keep1 = b1_full_q & ~gnt1;

  always_comb begin
    b0_full_d = load0 | keep0;
    b1_full_d = load1 | keep1;
    b0_rd_d   = load0 ? s0_rd   : b0_rd_q;
    b0_data_d = load0 ? s0_data : b0_data_q;
    b1_rd_d   = load1 ? s1_rd   : b1_rd_q;
    b1_data_d = load1 ? s1_data : b1_data_q;

    // A buffer loading alone is younger than a buffer that stays full.
    // When both buffers load together, source 0 counts as older.
    older0_d = older0_q;
    if (load1)      older0_d = 1'b1;
    else if (load0) older0_d = ~keep1;

    last_d  = (gnt0 | gnt1) ? gnt1 : last_q;
    rf_le_d = gnt0 | gnt1;
    rf_rw_d = rf_rw_q;
    rf_pw_d = rf_pw_q;
    if (gnt0) begin
      rf_rw_d = b0_rd_q;
      rf_pw_d = b0_data_q;
    end else if (gnt1) begin
      rf_rw_d = b1_rd_q;
      rf_pw_d = b1_data_q;
    end
    wr_err_d = (acc0 & pc0) | (acc1 & pc1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b0_full_q <= 1'b0;
      b1_full_q <= 1'b0;
      b0_rd_q   <= '0;
      b0_data_q <= '0;
      b1_rd_q   <= '0;
      b1_data_q <= '0;
      older0_q  <= 1'b1;
      last_q    <= 1'b1;
      rf_le_q   <= 1'b0;
      rf_rw_q   <= '0;
      rf_pw_q   <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      b0_full_q <= b0_full_d;
      b1_full_q <= b1_full_d;
      b0_rd_q   <= b0_rd_d;
      b0_data_q <= b0_data_d;
      b1_rd_q   <= b1_rd_d;
      b1_data_q <= b1_data_d;
      older0_q  <= older0_d;
      last_q    <= last_d;
      rf_le_q   <= rf_le_d;
      rf_rw_q   <= rf_rw_d;
      rf_pw_q   <= rf_pw_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign rf_le  = rf_le_q;
  assign rf_rw  = rf_rw_q;
  assign rf_pw  = rf_pw_q;
  assign wr_err = wr_err_q;

  always_comb begin
    pending_mask = '0;
    if (b0_full_q) pending_mask = pending_mask | (16'd1 << b0_rd_q);
    if (b1_full_q) pending_mask = pending_mask | (16'd1 << b1_rd_q);
    if (rf_le_q)   pending_mask = pending_mask | (16'd1 << rf_rw_q);
  end

`ifdef RFWB_FWD_EN
  logic hit0, hit1, hitp;

  assign hit0 = b0_full_q & (b0_rd_q == fwd_ra);
  assign hit1 = b1_full_q & (b1_rd_q == fwd_ra);
  assign hitp = rf_le_q & (rf_rw_q == fwd_ra);

  always_comb begin
    fwd_hit  = hit0 | hit1 | hitp;
    fwd_data = '0;
    // Newest value wins: younger buffer, then older buffer, then the port.
    if (hit0 && hit1)  fwd_data = older0_q ? b1_data_q : b0_data_q;
    else if (hit0)     fwd_data = b0_data_q;
    else if (hit1)     fwd_data = b1_data_q;
    else if (hitp)     fwd_data = rf_pw_q;
  end
`else
  logic unused_fwd_ra;

  assign unused_fwd_ra = ^fwd_ra;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter. Inputs change 1 ns after the rising
// edge. Outputs are sampled at that same point.
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic              s0_valid, s1_valid;
  logic              s0_ready, s1_ready;
  logic [ADDR_W-1:0] s0_rd, s1_rd;
  logic [DATA_W-1:0] s0_data, s1_data;
  logic              rf_le;
  logic [ADDR_W-1:0] rf_rw;
  logic [DATA_W-1:0] rf_pw;
  logic [15:0]       pending_mask;
  logic              wr_err;
  logic [ADDR_W-1:0] fwd_ra;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s0_rd        (s0_rd),
    .s0_data      (s0_data),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .s1_rd        (s1_rd),
    .s1_data      (s1_data),
    .rf_le        (rf_le),
    .rf_rw        (rf_rw),
    .rf_pw        (rf_pw),
    .pending_mask (pending_mask),
    .wr_err       (wr_err),
    .fwd_ra       (fwd_ra),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
    s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // scoreboard check
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [ADDR_W+DATA_W-1:0] e;
    logic a0, a1, exp_hit;
    logic [DATA_W-1:0] exp_fdata;
    int n0, n1, first_c, last_c;

    fwd_ra = '0;
    reset  = 1'b1;
    idle_inputs();
    tick();
    tick();

    // reset values
    check_eq("rst_rf_le", rf_le, 0);
    check_eq("rst_rf_rw", rf_rw, 0);
    check_eq("rst_rf_pw", rf_pw, 0);
    check_eq("rst_wr_err", wr_err, 0);
    check_eq("rst_pending", pending_mask, 0);
    check_eq("rst_fwd_hit", fwd_hit, 0);
    check_eq("rst_fwd_data", fwd_data, 0);
    check_eq("rst_s0_ready", s0_ready, 0);
    check_eq("rst_s1_ready", s1_ready, 0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_s0_ready", s0_ready, 1);
    check_eq("post_rst_s1_ready", s1_ready, 1);

    // single uncontested write R3 = 0xAA
    s0_valid = 1'b1; s0_rd = 4'd3; s0_data = 32'h0000_00AA;
    tick();
    s0_valid = 1'b0;
    check_eq("single_le_c1", rf_le, 0);
    check_eq("single_pend_c1", pending_mask, 16'h0008);
    tick();
    check_eq("single_le_c2", rf_le, 1);
    check_eq("single_rw_c2", rf_rw, 3);
    check_eq("single_pw_c2", rf_pw, 32'hAA);
    check_eq("single_pend_c2", pending_mask, 16'h0008);
    tick();
    check_eq("single_le_c3", rf_le, 0);
    check_eq("single_rw_hold", rf_rw, 3);
    check_eq("single_pend_c3", pending_mask, 16'h0000);

    // two contending streams: s0 -> R1, s1 -> R2, four writes each
    do_reset();
    exp_q = {};
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({4'd1, 32'h100 + k});
      exp_q.push_back({4'd2, 32'h200 + k});
    end
    n0 = 0; n1 = 0; first_c = -1; last_c = -1;
    for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
      s0_valid = (n0 < 4); s0_rd = 4'd1; s0_data = 32'h100 + n0;
      s1_valid = (n1 < 4); s1_rd = 4'd2; s1_data = 32'h200 + n1;
      #1;
      if (cyc >= 1 && cyc <= 7) check_eq("stream_ready_alt", s0_ready ^ s1_ready, 1);
      a0 = s0_valid & s0_ready;
      a1 = s1_valid & s1_ready;
      tick();
      n0 += int'(a0);
      n1 += int'(a1);
      if (rf_le) begin
        e = exp_q.pop_front();
        check_eq("stream_write", {rf_rw, rf_pw}, e);
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
    end
    idle_inputs();
    check_eq("stream_drained", exp_q.size(), 0);
    check_eq("stream_back_to_back", last_c - first_c, 7);

    // same-edge accept to the same register R5
    s0_valid = 1'b1; s0_rd = 4'd5; s0_data = 32'h11;
    s1_valid = 1'b1; s1_rd = 4'd5; s1_data = 32'h22;
    #1;
    check_eq("same_rd_both_ready", {s0_ready, s1_ready}, 2'b11);
    tick();
    idle_inputs();
    check_eq("same_rd_le_c1", rf_le, 0);
    check_eq("same_rd_pend_c1", pending_mask, 16'h0020);
    tick();
    check_eq("same_rd_first", {rf_le, rf_rw, rf_pw}, {1'b1, 4'd5, 32'h11});
    check_eq("same_rd_pend_c2", pending_mask, 16'h0020);
    tick();
    check_eq("same_rd_second", {rf_le, rf_rw, rf_pw}, {1'b1, 4'd5, 32'h22});
    check_eq("same_rd_pend_c3", pending_mask, 16'h0020);
    tick();
    check_eq("same_rd_le_c4", rf_le, 0);
    check_eq("same_rd_pend_c4", pending_mask, 16'h0000);

    // R15 write is rejected with a single wr_err pulse
    s1_valid = 1'b1; s1_rd = 4'd15; s1_data = 32'hDEAD;
    tick();
    idle_inputs();
    check_eq("r15_err_c1", wr_err, 1);
    check_eq("r15_le_c1", rf_le, 0);
    check_eq("r15_pend_c1", pending_mask, 0);
    tick();
    check_eq("r15_err_c2", wr_err, 0);
    check_eq("r15_le_c2", rf_le, 0);
    check_eq("r15_pend_c2", pending_mask, 0);
    s0_valid = 1'b1; s0_rd = 4'd15; s0_data = 32'h1;
    s1_valid = 1'b1; s1_rd = 4'd15; s1_data = 32'h2;
    tick();
    idle_inputs();
    check_eq("r15_both_err_c1", wr_err, 1);
    tick();
    check_eq("r15_both_err_c2", wr_err, 0);
    check_eq("r15_both_le", rf_le, 0);

    // reset while R7 is on the port and s1 holds R8 behind it
    s0_valid = 1'b1; s0_rd = 4'd7; s0_data = 32'h70;
    s1_valid = 1'b1; s1_rd = 4'd8; s1_data = 32'h80;
    tick();
    s0_valid = 1'b0;
    s1_data  = 32'h81;
    #1;
    check_eq("mid_s1_blocked", s1_ready, 0);
    check_eq("mid_s0_free", s0_ready, 1);
    tick();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_readies", {s0_ready, s1_ready}, 2'b00);
    check_eq("mid_rst_port", {rf_le, rf_rw, rf_pw}, {1'b1, 4'd7, 32'h70});
    check_eq("mid_rst_pend", pending_mask, 16'h0180);
    tick();
    reset = 1'b0;
    idle_inputs();
    check_eq("mid_after_le", rf_le, 0);
    check_eq("mid_after_rw", rf_rw, 0);
    check_eq("mid_after_pend", pending_mask, 0);
    tick();
    check_eq("mid_after_le2", rf_le, 0);
    check_eq("mid_after_pend2", pending_mask, 0);

    // forwarding: R9=0x1234 on the port, R9=0x5678 buffered behind it
`ifdef RFWB_FWD_EN
    exp_hit = 1'b1; exp_fdata = 32'h5678;
`else
    exp_hit = 1'b0; exp_fdata = 32'h0;
`endif
    s0_valid = 1'b1; s0_rd = 4'd9; s0_data = 32'h1234;
    tick();
    s0_data = 32'h5678;
    tick();
    idle_inputs();
    fwd_ra = 4'd9;
    #1;
    check_eq("fwd_port_state", {rf_le, rf_rw, rf_pw}, {1'b1, 4'd9, 32'h1234});
    check_eq("fwd_pend", pending_mask, 16'h0200);
    check_eq("fwd_hit_r9", fwd_hit, exp_hit);
    check_eq("fwd_data_r9", fwd_data, exp_fdata);
    fwd_ra = 4'd4;
    #1;
    check_eq("fwd_hit_r4", fwd_hit, 0);
    fwd_ra = 4'd9;
    tick();
    check_eq("fwd_port_second", {rf_le, rf_pw}, {1'b1, 32'h5678});
    check_eq("fwd_data_port", fwd_data, exp_fdata);
    tick();
    check_eq("fwd_hit_empty", fwd_hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
